debug_dump: RTL and testbench
=============================

DEBUG_DUMP -- requirements
Module: debug_dump

Interface
REQ-001 Parameter HEADER, default 8'hA5, frame start byte sent before the captured data.
REQ-002 Parameter LAST_IDX, default 8, index of the final byte in the frame (frame = 9 bytes).
REQ-003 i_clk  input  1  system clock; all state updates on posedge.
REQ-004 i_rst  input  1  reset; synchronous to i_clk and active-high.
REQ-005 i_Halt  input  1  level; the pipeline has halted and PC is frozen.
REQ-006 i_pc  input  32  current program counter from the PC stage.
REQ-007 i_clk_counter  input  32  free-running cycle count from the PC stage.
REQ-008 i_tx_done  input  1  one-cycle pulse from the UART transmitter: the byte it was sending has finished.
REQ-009 o_tx_start  output  1  one-cycle pulse: transmitter loads o_tx_data.
REQ-010 o_tx_data  output  8  byte to transmit; valid while o_tx_start is high and held until the next o_tx_start.
REQ-011 o_busy  output  1  high while a frame is in progress.
REQ-012 o_dump_done  output  1  high once the full frame has been acknowledged.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, SEND, WAIT, DONE.
REQ-014 IDLE: when i_Halt=1 is sampled, the block SHALL capture i_pc and i_clk_counter into internal registers on that edge, clear byte index to 0, and go to SEND.
REQ-015 SEND: for exactly one cycle, o_tx_start SHALL be 1 and o_tx_data SHALL be the byte at the current index; the next state SHALL be WAIT.
REQ-016 Byte order SHALL be: idx0=HEADER, idx1..4 = captured PC [31:24],[23:16],[15:8],[7:0], idx5..8 = captured count [31:24]..[7:0].
REQ-017 WAIT: on i_tx_done=1, if index==LAST_IDX the next state SHALL be DONE; otherwise the index SHALL increment and the next state SHALL be SEND.
REQ-018 WAIT with i_tx_done=0 SHALL hold state, index and o_tx_data indefinitely.
REQ-019 i_tx_done SHALL be ignored in IDLE, SEND and DONE.
REQ-020 Latency: first o_tx_start SHALL occur 1 cycle after the edge that samples i_Halt=1; each later o_tx_start SHALL occur 1 cycle after the i_tx_done that acknowledges the previous byte.
REQ-021 i_Halt and the i_pc/i_clk_counter inputs SHALL be ignored outside IDLE; the frame SHALL carry only the values captured at frame start.
REQ-022 o_busy SHALL be 1 in SEND and WAIT and 0 in IDLE and DONE.
REQ-023 DONE SHALL be terminal: o_dump_done=1, o_tx_start=0, and no further frames until reset, even if i_Halt stays high.
REQ-024 The index SHALL be a 4-bit register; values above LAST_IDX SHALL be unreachable.

Reset
REQ-025 On i_rst=1 sampled, the block SHALL go to IDLE with o_tx_start=0, o_tx_data=8'h00, o_busy=0, o_dump_done=0, index=0, and captured registers=0.
REQ-026 Reset SHALL take priority over every other input in the same cycle, including i_Halt and i_tx_done.
REQ-027 Reset asserted mid-frame SHALL abort the frame without any further o_tx_start; after release with i_Halt=1, a fresh full frame SHALL start from idx0.

Verification
REQ-028 Scenario 1: reset, then i_Halt=1 with i_pc=32'h0000_0040 and i_clk_counter=32'h0000_012C; ack each byte 3 cycles after its o_tx_start -> bytes A5,00,00,00,40,00,00,01,2C, then o_dump_done=1 and o_busy=0.
REQ-029 Scenario 2: i_pc and i_clk_counter change every cycle after the capture edge -> transmitted bytes equal the capture-edge values.
REQ-030 Scenario 3: i_tx_done pulses in IDLE and in SEND -> no index advance and no extra o_tx_start.
REQ-031 Scenario 4: i_rst pulsed in WAIT after byte idx3 with i_Halt held high -> o_tx_start stays 0 during reset; the next frame restarts at A5 with the new capture.
REQ-032 Scenario 5: i_Halt and i_rst both high in the same cycle -> state stays IDLE and o_busy=0.
REQ-033 Scenario 6: after DONE, hold i_Halt=1 for 100 cycles and pulse i_tx_done -> no o_tx_start and o_dump_done stays 1.

Source files
------------

// File: rtl/debug_dump.sv
// Debug frame dumper: on halt, captures PC and cycle count and streams
// HEADER + PC + count as a byte frame through a handshaked UART transmitter.
module debug_dump #(
    parameter logic [7:0]  HEADER   = 8'hA5,
    parameter int unsigned LAST_IDX = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_Halt,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_clk_counter,
    input  logic        i_tx_done,
    output logic        o_tx_start,
    output logic [7:0]  o_tx_data,
    output logic        o_busy,
    output logic        o_dump_done
);

    localparam int unsigned IDX_W  = 4;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WORD_W-1:0]   pc_q, pc_d;
    logic [WORD_W-1:0]   cnt_q, cnt_d;
    logic                tx_start_q, tx_start_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic                busy_q, busy_d;
    logic                dump_done_q, dump_done_d;

    // Frame byte at a given index: header, PC MSB-first, count MSB-first.
    function automatic logic [BYTE_W-1:0] byte_sel(
        input logic [IDX_W-1:0]  idx,
        input logic [WORD_W-1:0] pc,
        input logic [WORD_W-1:0] cnt
    );
        case (idx)
            4'd0:    byte_sel = HEADER;
            4'd1:    byte_sel = pc[31:24];
            4'd2:    byte_sel = pc[23:16];
            4'd3:    byte_sel = pc[15:8];
            4'd4:    byte_sel = pc[7:0];
            4'd5:    byte_sel = cnt[31:24];
            4'd6:    byte_sel = cnt[23:16];
            4'd7:    byte_sel = cnt[15:8];
            4'd8:    byte_sel = cnt[7:0];
            default: byte_sel = 8'h00;
        endcase
    endfunction

    // Next-state and next-output logic; outputs are decided one cycle ahead
    // so the registered o_tx_start coincides with the SEND state.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;

        case (state_q)
            IDLE: begin
                if (i_Halt) begin
                    pc_d       = i_pc;
                    cnt_d      = i_clk_counter;
                    idx_d      = '0;
                    state_d    = SEND;
                    tx_start_d = 1'b1;
                    tx_data_d  = byte_sel('0, i_pc, i_clk_counter);
                end
            end
            SEND: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (i_tx_done) begin
                    if (idx_q == IDX_W'(LAST_IDX)) begin
                        state_d = DONE;
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        state_d    = SEND;
                        tx_start_d = 1'b1;
                        tx_data_d  = byte_sel(idx_q + IDX_W'(1), pc_q, cnt_q);
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d == SEND) || (state_d == WAIT);
        dump_done_d = (state_d == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pc_q        <= '0;
            cnt_q       <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            busy_q      <= 1'b0;
            dump_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            dump_done_q <= dump_done_d;
        end
    end

    assign o_tx_start  = tx_start_q;
    assign o_tx_data   = tx_data_q;
    assign o_busy      = busy_q;
    assign o_dump_done = dump_done_q;

endmodule

// File: tb/tb_debug_dump.sv
// Directed self-checking bench for debug_dump.
module tb_debug_dump;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_Halt = 1'b0;
    logic [31:0] i_pc = '0;
    logic [31:0] i_clk_counter = '0;
    logic        i_tx_done = 1'b0;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        o_busy;
    logic        o_dump_done;

    int n_checks = 0;
    int n_err    = 0;
    int n_start  = 0;

    debug_dump dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_Halt        (i_Halt),
        .i_pc          (i_pc),
        .i_clk_counter (i_clk_counter),
        .i_tx_done     (i_tx_done),
        .o_tx_start    (o_tx_start),
        .o_tx_data     (o_tx_data),
        .o_busy        (o_busy),
        .o_dump_done   (o_dump_done)
    );

    always #5 i_clk = ~i_clk;

    // Count every transmit-start pulse seen by the DUT's consumer.
    always @(posedge i_clk) if (o_tx_start === 1'b1) n_start <= n_start + 1;

    // Advance one cycle, sampling point 1 time unit after the rising edge.
    task automatic step(input bit scramble);
        @(posedge i_clk);
        #1;
        if (scramble) begin
            i_pc          = $urandom;
            i_clk_counter = $urandom;
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step(0);
        i_rst = 1'b0;
    endtask

    // Wait (bounded) for a start pulse, return byte and cycles waited,
    // then optionally ack it 3 cycles after the start.
    task automatic get_byte(input bit do_ack, input bit scramble,
                            output logic [7:0] b, output int lat);
        lat = -1;
        b   = 8'hxx;
        for (int i = 0; i < 20; i++) begin
            if (o_tx_start === 1'b1) begin
                lat = i;
                break;
            end
            step(scramble);
        end
        if (lat >= 0) begin
            b = o_tx_data;
            if (do_ack) begin
                step(scramble);
                step(scramble);
                i_tx_done = 1'b1;
                step(scramble);
                i_tx_done = 1'b0;
            end
        end
    endtask

    // Receive and check a full acknowledged frame against {HEADER, pc, cnt}.
    task automatic check_frame(input string name, input logic [71:0] exp,
                               input bit scramble, input int first_lat);
        logic [7:0] b;
        int lat;
        for (int i = 0; i < 9; i++) begin
            get_byte(1'b1, scramble, b, lat);
            n_checks++;
            if (b !== exp[71-8*i -: 8]) begin
                n_err++;
                $display("FAIL %s byte%0d: got %h expected %h", name, i, b, exp[71-8*i -: 8]);
            end
            n_checks++;
            if (lat !== ((i == 0) ? first_lat : 0)) begin
                n_err++;
                $display("FAIL %s latency%0d: got %0d expected %0d", name, i, lat,
                         (i == 0) ? first_lat : 0);
            end
        end
        n_checks++;
        if (o_dump_done !== 1'b1 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s end: done=%b busy=%b expected done=1 busy=0", name, o_dump_done, o_busy);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_Halt = 1'b1; i_tx_done = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step(0);
            n_checks++;
            if ({o_tx_start, o_tx_data, o_busy, o_dump_done} !== 11'h000) begin
                n_err++;
                $display("FAIL reset_vs_halt: start=%b data=%h busy=%b done=%b expected all 0",
                         o_tx_start, o_tx_data, o_busy, o_dump_done);
            end
        end
        i_rst = 1'b0; i_Halt = 1'b0; i_tx_done = 1'b0;
        step(0);
        n_checks++;
        if (o_busy !== 1'b0 || o_tx_start !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: busy=%b start=%b expected 0 0", o_busy, o_tx_start);
        end
    endtask

    task automatic test_frame();
        do_reset();
        i_Halt = 1'b1; i_pc = 32'h0000_0040; i_clk_counter = 32'h0000_012C;
        check_frame("frame", 72'hA5_0000_0040_0000_012C, 0, 1);
    endtask

    task automatic test_capture_hold();
        do_reset();
        i_Halt = 1'b1; i_pc = 32'h1234_5678; i_clk_counter = 32'h9ABC_DEF0;
        check_frame("capture", 72'hA5_1234_5678_9ABC_DEF0, 1, 1);
    endtask

    task automatic test_ignored_done();
        int s0;
        do_reset();
        s0 = n_start;
        i_Halt = 1'b0; i_tx_done = 1'b1;
        repeat (3) step(0);
        i_tx_done = 1'b0;
        step(0);
        n_checks++;
        if (n_start !== s0 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_in_idle: starts=%0d busy=%b expected %0d 0", n_start - s0, o_busy, 0);
        end
        i_Halt = 1'b1; i_pc = 32'hAABB_CCDD; i_clk_counter = 32'h0102_0304; i_tx_done = 1'b1;
        step(0);
        i_Halt = 1'b0;
        n_checks++;
        if (o_tx_start !== 1'b1 || o_tx_data !== 8'hA5) begin
            n_err++;
            $display("FAIL send_hdr: start=%b data=%h expected 1 a5", o_tx_start, o_tx_data);
        end
        step(0);
        i_tx_done = 1'b0;
        n_checks++;
        if (o_tx_start !== 1'b0) begin
            n_err++;
            $display("FAIL start_width: start=%b expected 0", o_tx_start);
        end
        repeat (5) step(0);
        n_checks++;
        if (n_start !== s0 + 1 || o_tx_data !== 8'hA5 || o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL wait_hold: starts=%0d data=%h busy=%b expected 1 a5 1",
                     n_start - s0, o_tx_data, o_busy);
        end
        i_tx_done = 1'b1;
        step(0);
        i_tx_done = 1'b0;
        n_checks++;
        if (o_tx_start !== 1'b1 || o_tx_data !== 8'hAA) begin
            n_err++;
            $display("FAIL idx1_after_ack: start=%b data=%h expected 1 aa", o_tx_start, o_tx_data);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        int lat;
        int s0;
        logic [7:0] exp [4];
        exp[0] = 8'hA5; exp[1] = 8'h11; exp[2] = 8'h11; exp[3] = 8'h11;
        do_reset();
        i_Halt = 1'b1; i_pc = 32'h1111_1111; i_clk_counter = 32'h2222_2222;
        for (int i = 0; i < 4; i++) begin
            get_byte(i < 3, 0, b, lat);
            n_checks++;
            if (b !== exp[i]) begin
                n_err++;
                $display("FAIL mid_byte%0d: got %h expected %h", i, b, exp[i]);
            end
        end
        step(0);
        s0 = n_start;
        i_rst = 1'b1; i_tx_done = 1'b1; i_pc = 32'h3333_3333; i_clk_counter = 32'h4444_4444;
        for (int k = 0; k < 2; k++) begin
            step(0);
            n_checks++;
            if (o_tx_start !== 1'b0 || o_busy !== 1'b0) begin
                n_err++;
                $display("FAIL mid_reset%0d: start=%b busy=%b expected 0 0", k, o_tx_start, o_busy);
            end
        end
        i_rst = 1'b0; i_tx_done = 1'b0;
        n_checks++;
        if (n_start !== s0) begin
            n_err++;
            $display("FAIL mid_reset_starts: got %0d expected 0", n_start - s0);
        end
        check_frame("restart", 72'hA5_3333_3333_4444_4444, 0, 1);
    endtask

    task automatic test_done_terminal();
        int s0;
        int bad;
        s0  = n_start;
        bad = 0;
        i_Halt = 1'b1;
        for (int i = 0; i < 100; i++) begin
            i_tx_done = (i == 50);
            step(0);
            if (o_tx_start !== 1'b0 || o_dump_done !== 1'b1 || o_busy !== 1'b0) bad++;
        end
        i_tx_done = 1'b0;
        n_checks++;
        if (bad !== 0 || n_start !== s0) begin
            n_err++;
            $display("FAIL done_terminal: bad_cycles=%0d starts=%0d expected 0 0", bad, n_start - s0);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_frame();
        test_capture_hold();
        test_ignored_done();
        test_reset_mid();
        test_done_terminal();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
